// File: rtl/div_result_capture.sv
`default_nettype none
// ============================================================================
// Module   : div_result_capture
// Brief    : div_clock-domain capture of DEPTH crossed result words after a
//            settle delay, with a registered read port. Optional word compare
//            against exp_in is enabled by defining CAPTURE_COMPARE_EN.
// Revision : 1.0  initial release
// ============================================================================
module div_result_capture #(
  parameter int WIDTH         = 32,
  parameter int DEPTH         = 16,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   div_clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       data_in,
  input  logic [WIDTH-1:0]       exp_in,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] wr_count,
  input  logic                   rd_en,
  input  logic [$clog2(DEPTH):0] rd_addr,
  output logic [WIDTH-1:0]       rd_data,
  output logic [15:0]            mismatch_count
);

  localparam int c_AW = $clog2(DEPTH) + 1;
  localparam int c_IW = c_AW - 1;
  localparam int c_SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [c_SW-1:0] c_SETTLE_INIT = c_SW'(SETTLE_CYCLES);
  localparam logic [c_SW-1:0] c_SETTLE_LAST = c_SW'(1);
  localparam logic [c_AW-1:0] c_LAST_IDX    = c_AW'(DEPTH - 1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_SETTLE  = 2'd1;
  localparam logic [1:0] c_ST_CAPTURE = 2'd2;
  localparam logic [1:0] c_ST_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [c_SW-1:0]  r_settle_cnt;
  logic [c_AW-1:0]  r_wr_count;
  logic [WIDTH-1:0] r_rd_data;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic             w_arm;
  logic             w_capture;

  assign w_arm     = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
  assign w_capture = (r_state == c_ST_CAPTURE);

  always_ff @(posedge div_clock) begin
    if (reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // A settle count of 0 or 1 both leave SETTLE after its first cycle.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE, c_ST_DONE: begin
        if (start) w_next_state = c_ST_SETTLE;
      end
      c_ST_SETTLE: begin
        if (r_settle_cnt <= c_SETTLE_LAST) w_next_state = c_ST_CAPTURE;
      end
      c_ST_CAPTURE: begin
        if (r_wr_count == c_LAST_IDX) w_next_state = c_ST_DONE;
      end
      default: w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == c_ST_SETTLE) || (r_state == c_ST_CAPTURE);
    done = (r_state == c_ST_DONE);
  end

  always_ff @(posedge div_clock) begin
    if (reset) begin
      r_settle_cnt <= '0;
      r_wr_count   <= '0;
    end else if (w_arm) begin
      r_settle_cnt <= c_SETTLE_INIT;
      r_wr_count   <= '0;
    end else begin
      if ((r_state == c_ST_SETTLE) && (r_settle_cnt != '0)) begin
        r_settle_cnt <= r_settle_cnt - 1'b1;
      end
      if (w_capture) begin
        r_wr_count <= r_wr_count + 1'b1;
      end
    end
  end

  // Buffer is never cleared; a reset edge only suppresses the write.
  always_ff @(posedge div_clock) begin
    if (!reset && w_capture) begin
      r_buf[r_wr_count[c_IW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge div_clock) begin
    if (reset) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      if (rd_addr[c_AW-1]) begin
        r_rd_data <= '0;
      end else begin
        r_rd_data <= r_buf[rd_addr[c_IW-1:0]];
      end
    end
  end

  assign wr_count = r_wr_count;
  assign rd_data  = r_rd_data;

`ifdef CAPTURE_COMPARE_EN
  logic [15:0] r_mismatch_count;

  always_ff @(posedge div_clock) begin
    if (reset || w_arm) begin
      r_mismatch_count <= '0;
    end else if (w_capture && (data_in != exp_in) && (r_mismatch_count != 16'hFFFF)) begin
      r_mismatch_count <= r_mismatch_count + 1'b1;
    end
  end

  assign mismatch_count = r_mismatch_count;
`else
  logic w_unused_exp;

  assign w_unused_exp   = ^exp_in;
  assign mismatch_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_result_capture.sv
`default_nettype none
// Bench for div_result_capture: two instances (SETTLE_CYCLES 2 and 0) share
// stimulus and are compared every cycle against a timeline-based reference.
module tb_div_result_capture;

  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH) + 1;
  // Cycles spent in SETTLE for SETTLE_CYCLES = 2 and = 0
  localparam int SETTLE_LEN [2] = '{2, 1};
`ifdef CAPTURE_COMPARE_EN
  localparam int EXP_MIS = 3;
`else
  localparam int EXP_MIS = 0;
`endif

  logic             div_clock = 1'b0;
  logic             reset     = 1'b1;
  logic             start     = 1'b0;
  logic             rd_en     = 1'b0;
  logic [AW-1:0]    rd_addr   = '0;
  logic [WIDTH-1:0] data_in   = '0;
  logic [WIDTH-1:0] exp_in    = '0;

  logic             busy0, done0, busy1, done1;
  logic [AW-1:0]    wr_count0, wr_count1;
  logic [WIDTH-1:0] rd_data0, rd_data1;
  logic [15:0]      mismatch_count0, mismatch_count1;

  always #5 div_clock = ~div_clock;

  div_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(2)) u_dut0 (
    .div_clock(div_clock), .reset(reset), .data_in(data_in), .exp_in(exp_in),
    .start(start), .busy(busy0), .done(done0), .wr_count(wr_count0),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0),
    .mismatch_count(mismatch_count0)
  );

  div_result_capture #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SETTLE_CYCLES(0)) u_dut1 (
    .div_clock(div_clock), .reset(reset), .data_in(data_in), .exp_in(exp_in),
    .start(start), .busy(busy1), .done(done1), .wr_count(wr_count1),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .mismatch_count(mismatch_count1)
  );

  // Reference: a run is the edge index t0 where start was accepted; every
  // other quantity follows from arithmetic on the current edge index.
  logic [WIDTH-1:0] m_buf   [2][DEPTH];
  bit               m_valid [2][DEPTH];
  bit               m_run   [2];
  int               m_t0    [2];
  int               m_wr    [2];
  int               m_mis   [2];
  logic [WIDTH-1:0] m_rd    [2];
  bit               m_rd_known [2];
  int               cyc     = 0;
  int               n_tests = 0;
  int               n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_step();
    int s;
    int idx;
    bit busy_pre;
    bit cap;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      s = SETTLE_LEN[i];
      if (reset) begin
        m_run[i] = 1'b0; m_wr[i] = 0; m_mis[i] = 0;
        m_rd[i] = '0; m_rd_known[i] = 1'b1;
      end else begin
        busy_pre = m_run[i] && (cyc > m_t0[i]) && (cyc <= m_t0[i] + s + DEPTH);
        cap      = m_run[i] && (cyc > m_t0[i] + s) && (cyc <= m_t0[i] + s + DEPTH);
        if (rd_en) begin
          if (int'(rd_addr) >= DEPTH) begin
            m_rd[i] = '0; m_rd_known[i] = 1'b1;
          end else begin
            m_rd[i] = m_buf[i][int'(rd_addr)];
            m_rd_known[i] = m_valid[i][int'(rd_addr)];
          end
        end
        if (cap) begin
          idx = cyc - m_t0[i] - s - 1;
          m_buf[i][idx] = data_in;
          m_valid[i][idx] = 1'b1;
          m_wr[i] = idx + 1;
`ifdef CAPTURE_COMPARE_EN
          if ((data_in != exp_in) && (m_mis[i] < 65535)) m_mis[i]++;
`endif
        end
        if (start && !busy_pre) begin
          m_t0[i] = cyc; m_run[i] = 1'b1; m_wr[i] = 0; m_mis[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    int s;
    bit e_busy;
    bit e_done;
    for (int i = 0; i < 2; i++) begin
      s = SETTLE_LEN[i];
      e_busy = m_run[i] && (cyc >= m_t0[i]) && (cyc < m_t0[i] + s + DEPTH);
      e_done = m_run[i] && (cyc >= m_t0[i] + s + DEPTH);
      check($sformatf("busy%0d", i), (i == 0) ? busy0 : busy1, e_busy);
      check($sformatf("done%0d", i), (i == 0) ? done0 : done1, e_done);
      check($sformatf("wr_count%0d", i), (i == 0) ? wr_count0 : wr_count1, 64'(m_wr[i]));
      check($sformatf("mismatch%0d", i), (i == 0) ? mismatch_count0 : mismatch_count1,
            64'(m_mis[i]));
      if (m_rd_known[i]) begin
        check($sformatf("rd_data%0d", i), (i == 0) ? rd_data0 : rd_data1, m_rd[i]);
      end
    end
  endtask

  task automatic tick(input bit r, input bit st, input bit re, input int ra,
                      input logic [WIDTH-1:0] din, input logic [WIDTH-1:0] ein);
    reset = r; start = st; rd_en = re; rd_addr = AW'(ra);
    data_in = din; exp_in = ein;
    @(posedge div_clock);
    model_step();
    #1;
    check_all();
  endtask

  initial begin
    int t1, t2, t3, idx;
    logic [WIDTH-1:0] d, e;

    repeat (3) tick(1, 0, 0, 0, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    repeat (6) tick(0, 0, 0, 0, WIDTH'(cyc + 1), WIDTH'(cyc + 1));

    // Run 1: data is the edge index; a second start mid-run must be ignored
    tick(0, 1, 0, 0, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    t1 = cyc;
    for (int j = 1; j <= 24; j++) tick(0, (j == 5), 0, 0, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    check("run1_done0", done0, 1);
    check("run1_done1", done1, 1);
    check("run1_wr0", wr_count0, DEPTH);

    for (int a = 0; a <= DEPTH; a++) begin
      tick(0, 0, 1, a, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
      check($sformatf("readback0_%0d", a), rd_data0, (a < DEPTH) ? 64'(t1 + 3 + a) : 64'd0);
      check($sformatf("readback1_%0d", a), rd_data1, (a < DEPTH) ? 64'(t1 + 2 + a) : 64'd0);
    end
    tick(0, 0, 1, 5, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    repeat (2) tick(0, 0, 0, 9, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    check("rd_hold0", rd_data0, 64'(t1 + 8));

    // Run 2 from DONE: read the index being written, then abort with reset
    tick(0, 1, 0, 0, WIDTH'(cyc + 1001), WIDTH'(cyc + 1001));
    t2 = cyc;
    check("run2_wr_cleared", wr_count0, 0);
    for (int j = 1; j <= 12; j++) begin
      idx = cyc + 1 - t2 - 3;
      tick(0, 0, (idx >= 0), (idx >= 0) ? idx : 0, WIDTH'(cyc + 1001), WIDTH'(cyc + 1001));
      if (idx == 4) check("same_idx_old0", rd_data0, 64'(t1 + 7));
    end
    repeat (3) tick(1, 0, 1, 3, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_wr0", wr_count0, 0);
    check("rst_rd0", rd_data0, 0);
    check("rst_wr1", wr_count1, 0);
    repeat (4) tick(0, 0, 0, 0, WIDTH'(cyc + 1), WIDTH'(cyc + 1));
    check("idle_busy0", busy0, 0);
    check("idle_done0", done0, 0);

    // Run 3: exactly three corrupted expected words inside both capture windows
    tick(0, 1, 0, 0, WIDTH'($urandom), WIDTH'($urandom));
    t3 = cyc;
    for (int j = 1; j <= 22; j++) begin
      idx = cyc + 1 - t3 - 3;
      d = WIDTH'($urandom);
      e = d;
      if (idx == 2 || idx == 7 || idx == 11) e = d ^ (32'h1 << $urandom_range(0, 31));
      tick(0, 0, 0, 0, d, e);
    end
    check("cmp_mis0", mismatch_count0, 64'(EXP_MIS));
    check("cmp_mis1", mismatch_count1, 64'(EXP_MIS));
    check("cmp_done0", done0, 1);

    for (int j = 0; j < 2000; j++) begin
      d = WIDTH'($urandom);
      e = ($urandom_range(0, 7) == 0) ? (d ^ WIDTH'($urandom)) : d;
      tick(($urandom_range(0, 149) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 1) == 1), $urandom_range(0, DEPTH + 3), d, e);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
